// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: handshake, payload and counter bundle of one pipeline stage register.
// master = surrounding pipeline (upstream/downstream/hazard unit), slave = the stage register.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_bubble;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_bubble, stall_cnt, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_bubble, stall_cnt, drop_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready handshake, flush-to-bubble
// and saturating stall/drop counters.
// Define PIPE_STAGE_SKID_EN to add a skid entry so in_ready has no path from out_ready.
module pipe_stage_reg #(
    parameter int unsigned DATA_W        = 64,
    parameter int unsigned ZERO_ON_FLUSH = 1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_stage_reg_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_q, skid_d;
`endif
    logic              bubble_q, bubble_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic              in_ready_c;
    logic              out_valid_c;
    logic              in_xfer;
    logic              out_xfer;
    logic [1:0]        held;
    logic [CNT_W:0]    drop_sum;

    // State, payload and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            main_q   <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_q   <= '0;
`endif
            bubble_q <= 1'b0;
            stall_q  <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_q   <= skid_d;
`endif
            bubble_q <= bubble_d;
            stall_q  <= stall_d;
            drop_q   <= drop_d;
        end
    end

    // Next state: flush overrides every handshake transition
    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d   = skid_q;
`endif
        bubble_d = bubble_q;
        stall_d  = stall_q;
        drop_d   = drop_q;
        held     = (state_q == ST_FULL) ? 2'd2 : ((state_q == ST_ONE) ? 2'd1 : 2'd0);
        drop_sum = {1'b0, drop_q} + (CNT_W+1)'(held) + (CNT_W+1)'(bus.in_valid);

        if (bus.flush) begin
            state_d  = ST_EMPTY;
            bubble_d = 1'b1;
            if (ZERO_ON_FLUSH != 0) begin
                main_d = '0;
`ifdef PIPE_STAGE_SKID_EN
                skid_d = '0;
`endif
            end
            drop_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end else begin
            if (out_valid_c && !bus.out_ready && (stall_q != '1)) begin
                stall_d = stall_q + CNT_W'(1);
            end
            if (in_xfer) begin
                bubble_d = 1'b0;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d = ST_ONE;
                        main_d  = bus.in_data;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = bus.in_data;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_xfer) begin
                        state_d = ST_FULL;
                        skid_d  = bus.in_data;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                ST_FULL: begin
                    if (bus.out_ready) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
`endif
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        out_valid_c = (state_q != ST_EMPTY);
`ifdef PIPE_STAGE_SKID_EN
        in_ready_c  = (state_q != ST_FULL) || bus.flush;
`else
        in_ready_c  = !out_valid_c || bus.out_ready || bus.flush;
`endif
    end

    assign in_xfer        = bus.in_valid && in_ready_c;
    assign out_xfer       = out_valid_c && bus.out_ready;

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_data   = main_q;
    assign bus.out_bubble = bubble_q;
    assign bus.stall_cnt  = stall_q;
    assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks of pipe_stage_reg against a queue model.
module tb_pipe_stage_reg;

    localparam int unsigned DW  = 64;
    localparam int unsigned CW  = 32;
    localparam int unsigned SCW = 4;
    localparam bit          ZERO = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DW), .CNT_W(CW))  bus ();
    pipe_stage_reg_if #(.DATA_W(DW), .CNT_W(SCW)) sbus ();

    pipe_stage_reg #(.DATA_W(DW), .ZERO_ON_FLUSH(1), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pipe_stage_reg #(.DATA_W(DW), .ZERO_ON_FLUSH(1), .CNT_W(SCW)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of held entries with capacity CAP
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_hold;
    longint        m_stall;
    longint        m_drop;
    logic          m_bubble;
    logic          obs_rdy;
    logic          exp_rdy;

    function automatic longint sat(input longint x);
        return (x > CNT_MAX) ? CNT_MAX : x;
    endfunction

    function automatic logic [DW-1:0] exp_data();
        return (mq.size() > 0) ? mq[0] : m_hold;
    endfunction

    task automatic mdl_reset();
        mq.delete();
        m_hold   = '0;
        m_stall  = 0;
        m_drop   = 0;
        m_bubble = 1'b0;
    endtask

    // One clock of stimulus; starts and ends just after a falling edge
    task automatic drive_cycle(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        bus.flush     = f;
        #1;
        obs_rdy = bus.in_ready;
`ifdef PIPE_STAGE_SKID_EN
        exp_rdy = f || (mq.size() < 2);
`else
        exp_rdy = f || (mq.size() == 0) || r;
`endif
        @(posedge clk);
        if (f) begin
            m_drop = sat(m_drop + longint'(mq.size()) + (v ? 64'd1 : 64'd0));
            if (ZERO) m_hold = '0;
            else if (mq.size() > 0) m_hold = mq[0];
            mq.delete();
            m_bubble = 1'b1;
        end else begin
            if (mq.size() > 0 && !r) m_stall = sat(m_stall + 1);
            if (mq.size() > 0 && r) m_hold = mq.pop_front();
            if (v && exp_rdy) begin
                mq.push_back(d);
                m_bubble = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus.flush      = 1'b0;
        sbus.in_valid  = 1'b0;
        sbus.in_data   = '0;
        sbus.out_ready = 1'b0;
        sbus.flush     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mdl_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.out_data); end
        checks++; if (bus.out_bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got %b exp 0", bus.out_bubble); end
        checks++; if (bus.stall_cnt !== '0) begin errors++; $display("FAIL reset_stall got %0d exp 0", bus.stall_cnt); end
        checks++; if (bus.drop_cnt !== '0) begin errors++; $display("FAIL reset_drop got %0d exp 0", bus.drop_cnt); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(1'b1, DW'(i), 1'b1, 1'b0);
            checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %b exp 1", i, obs_rdy); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, bus.out_valid); end
            checks++; if (bus.out_data !== DW'(i)) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", i, bus.out_data, DW'(i)); end
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.stall_cnt !== '0) begin errors++; $display("FAIL stream_stall got %0d exp 0", bus.stall_cnt); end
    endtask

    task automatic test_backpressure();
        drive_cycle(1'b1, DW'(64'hA), 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive_cycle(1'b1, DW'(64'hB), 1'b0, 1'b0);
            checks++; if (obs_rdy !== ((CAP == 2) && (k == 0))) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp %b", k, obs_rdy, ((CAP == 2) && (k == 0))); end
            checks++; if (bus.out_data !== DW'(64'hA) || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got %b/%h exp 1/a", k, bus.out_valid, bus.out_data); end
        end
        checks++; if (bus.stall_cnt !== 32'd5) begin errors++; $display("FAIL bp_stall got %0d exp 5", bus.stall_cnt); end
        checks++; if (bus.stall_cnt !== CW'(m_stall)) begin errors++; $display("FAIL bp_stall_model got %0d exp %0d", bus.stall_cnt, m_stall); end
    endtask

    task automatic test_drain();
        drive_cycle(1'b1, DW'(64'hB), 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(64'hB)) begin errors++; $display("FAIL drain_first got %b/%h exp 1/b", bus.out_valid, bus.out_data); end
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL drain_in_ready got %b exp 1", bus.in_ready); end
        @(negedge clk);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_data !== exp_data()) begin errors++; $display("FAIL drain_data got %h exp %h", bus.out_data, exp_data()); end
        checks++; if (bus.stall_cnt !== 32'd5) begin errors++; $display("FAIL drain_stall got %0d exp 5", bus.stall_cnt); end
    endtask

    task automatic test_flush();
        drive_cycle(1'b1, DW'(64'hA), 1'b0, 1'b0);
        drive_cycle(1'b1, DW'(64'hB), 1'b0, 1'b0);
        drive_cycle(1'b1, DW'(64'hD), 1'b0, 1'b1);
        checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", obs_rdy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL flush_data got %h exp 0", bus.out_data); end
        checks++; if (bus.out_bubble !== 1'b1) begin errors++; $display("FAIL flush_bubble got %b exp 1", bus.out_bubble); end
        checks++; if (bus.drop_cnt !== CW'(CAP + 1)) begin errors++; $display("FAIL flush_drop got %0d exp %0d", bus.drop_cnt, CAP + 1); end
        checks++; if (bus.stall_cnt !== 32'd6) begin errors++; $display("FAIL flush_stall got %0d exp 6", bus.stall_cnt); end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (bus.out_bubble !== 1'b1) begin errors++; $display("FAIL flush_bubble_hold got %b exp 1", bus.out_bubble); end
        drive_cycle(1'b1, DW'(64'hC), 1'b1, 1'b0);
        checks++; if (bus.out_bubble !== 1'b0) begin errors++; $display("FAIL flush_bubble_clear got %b exp 0", bus.out_bubble); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(64'hC)) begin errors++; $display("FAIL flush_refill got %b/%h exp 1/c", bus.out_valid, bus.out_data); end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        @(negedge clk);
        drive_cycle(1'b1, DW'(64'h5), 1'b0, 1'b0);
        repeat (7) drive_cycle(1'b0, '0, 1'b0, 1'b0);
        checks++; if (bus.stall_cnt !== 32'd7 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got %0d/%b exp 7/1", bus.stall_cnt, bus.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL mid_data got %h exp 0", bus.out_data); end
        checks++; if (bus.stall_cnt !== '0 || bus.drop_cnt !== '0 || bus.out_bubble !== 1'b0) begin errors++; $display("FAIL mid_counters got %0d/%0d/%b exp 0/0/0", bus.stall_cnt, bus.drop_cnt, bus.out_bubble); end
        @(negedge clk);
        rst_n = 1'b1;
        mdl_reset();
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b exp 1", bus.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic          v, r, f;
        logic [DW-1:0] d;
        for (int n = 0; n < 600; n++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 15) == 0);
            d = {$urandom, $urandom};
            drive_cycle(v, d, r, f);
            checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready[%0d] got %b exp %b", n, obs_rdy, exp_rdy); end
            checks++; if (bus.out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", n, bus.out_valid, (mq.size() > 0)); end
            checks++; if (bus.out_data !== exp_data()) begin errors++; $display("FAIL rnd_data[%0d] got %h exp %h", n, bus.out_data, exp_data()); end
            checks++; if (bus.out_bubble !== m_bubble) begin errors++; $display("FAIL rnd_bubble[%0d] got %b exp %b", n, bus.out_bubble, m_bubble); end
            checks++; if (bus.stall_cnt !== CW'(m_stall)) begin errors++; $display("FAIL rnd_stall[%0d] got %0d exp %0d", n, bus.stall_cnt, m_stall); end
            checks++; if (bus.drop_cnt !== CW'(m_drop)) begin errors++; $display("FAIL rnd_drop[%0d] got %0d exp %0d", n, bus.drop_cnt, m_drop); end
        end
    endtask

    task automatic test_saturation();
        sbus.in_valid  = 1'b1;
        sbus.in_data   = DW'(64'h77);
        sbus.out_ready = 1'b0;
        sbus.flush     = 1'b0;
        @(negedge clk);
        sbus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (sbus.stall_cnt !== 4'd10) begin errors++; $display("FAIL sat_mid got %0d exp 10", sbus.stall_cnt); end
        repeat (10) @(negedge clk);
        checks++; if (sbus.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_top got %0d exp 15", sbus.stall_cnt); end
        repeat (3) @(negedge clk);
        checks++; if (sbus.stall_cnt !== 4'd15 || sbus.out_data !== DW'(64'h77)) begin errors++; $display("FAIL sat_hold got %0d/%h exp 15/77", sbus.stall_cnt, sbus.out_data); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_drain();
        test_flush();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
